// File: rtl/snes_pkg.sv
// Shared definitions for the SNES controller front end: console frame geometry,
// source-selection modes and the bit position of each button in a frame.
package snes_pkg;

    localparam int SNES_FRAME_W = 16;
    localparam int SNES_BTN_W   = 12;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_AUTO  = 2'd1,
        MODE_MERGE = 2'd2
    } mode_e;

    // Shift order on the console wire: B goes out first.
    typedef enum int unsigned {
        BTN_B      = 0,
        BTN_Y      = 1,
        BTN_SELECT = 2,
        BTN_START  = 3,
        BTN_UP     = 4,
        BTN_DOWN   = 5,
        BTN_LEFT   = 6,
        BTN_RIGHT  = 7,
        BTN_A      = 8,
        BTN_X      = 9,
        BTN_L      = 10,
        BTN_R      = 11
    } btn_idx_e;

endpackage

// File: rtl/src_hold_channel.sv
// One source's hold register. Timed channels drop their buttons HOLD_CYCLES clocks
// after the last strobe; level channels keep the last strobed vector indefinitely.
module src_hold_channel
    import snes_pkg::*;
#(
    parameter int BTN_W       = SNES_BTN_W,
    parameter bit TIMED       = 1'b0,
    parameter int HOLD_CYCLES = 20000,
    localparam int TMR_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [BTN_W-1:0] data,
    output logic [BTN_W-1:0] hold
);

    localparam bit              EXPIRES = TIMED && (HOLD_CYCLES != 0);
    // Loaded with HOLD_CYCLES-1 so the press stays visible for exactly HOLD_CYCLES clocks.
    localparam logic [TMR_W-1:0] RELOAD = (HOLD_CYCLES > 0) ? TMR_W'(HOLD_CYCLES - 1) : {TMR_W{1'b0}};

    logic [BTN_W-1:0] hold_r;
    logic [TMR_W-1:0] timer_r;

    // Capture on strobe, then count the timeout down and release at zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_r  <= {BTN_W{1'b0}};
            timer_r <= {TMR_W{1'b0}};
        end else if (valid) begin
            hold_r  <= data;
            timer_r <= EXPIRES ? RELOAD : {TMR_W{1'b0}};
        end else if (EXPIRES) begin
            if (timer_r == {TMR_W{1'b0}}) begin
                hold_r <= {BTN_W{1'b0}};
            end else begin
                timer_r <= timer_r - TMR_W'(1);
            end
        end
    end

    assign hold = hold_r;

endmodule

// File: rtl/snes_input_arbiter.sv
// N-source controller front end: per-source hold, FIXED/AUTO/MERGE selection and
// the console-facing latch/clock shift register.
module snes_input_arbiter
    import snes_pkg::*;
#(
    parameter int               N_SRC       = 3,
    parameter int               BTN_W       = SNES_BTN_W,
    parameter int               FRAME_W     = SNES_FRAME_W,
    parameter int               HOLD_CYCLES = 20000,
    parameter logic [N_SRC-1:0] HOLD_MASK   = N_SRC'(3'b110),
    localparam int              SEL_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_SRC*BTN_W-1:0] src_data,
    input  logic [N_SRC-1:0]       src_valid,
    input  logic [1:0]             mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   snes_clk,
    input  logic                   snes_latch,
    output logic                   snes_out,
    output logic [SEL_W-1:0]       active_src,
    output logic [BTN_W-1:0]       merged_btn,
    output logic                   frame_done
);

    localparam int CNT_W = $clog2(FRAME_W + 1);

    logic [BTN_W-1:0]   hold_s [N_SRC];
    logic [SEL_W-1:0]   owner_r, owner_next_s;
    logic [BTN_W-1:0]   vector_s, merged_btn_r;
    logic [SEL_W-1:0]   act_s, active_src_r;
    logic               nz_hit_s, held_hit_s;
    logic [SEL_W-1:0]   nz_idx_s, held_idx_s;
    logic [BTN_W-1:0]   or_s;
    logic               sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic               latch_meta_r, latch_sync_r;
    logic               sclk_rise_s;
    logic [FRAME_W-1:0] shreg_r, shreg_next_s;
    logic [CNT_W-1:0]   cnt_r, cnt_next_s;
    logic               done_next_s, frame_done_r, snes_out_r;

    // Active-low on the wire with unused trailing bits reading as released.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [BTN_W-1:0] v);
        logic [FRAME_W-1:0] f;
        f = {FRAME_W{1'b1}};
        f[BTN_W-1:0] = ~v;
        return f;
    endfunction

    genvar g;
    generate
        for (g = 0; g < N_SRC; g++) begin : g_ch
            src_hold_channel #(
                .BTN_W      (BTN_W),
                .TIMED      (HOLD_MASK[g]),
                .HOLD_CYCLES(HOLD_CYCLES)
            ) u_ch (
                .clk    (clk),
                .reset_n(reset_n),
                .valid  (src_valid[g]),
                .data   (src_data[g*BTN_W +: BTN_W]),
                .hold   (hold_s[g])
            );
        end
    endgenerate

    // AUTO ownership: newest nonzero strobe wins (lowest index on ties); fall back when owner goes idle.
    always_comb begin
        nz_hit_s   = 1'b0;
        nz_idx_s   = {SEL_W{1'b0}};
        held_hit_s = 1'b0;
        held_idx_s = {SEL_W{1'b0}};
        or_s       = {BTN_W{1'b0}};
        for (int i = N_SRC - 1; i >= 0; i--) begin
            nz_idx_s   = (src_valid[i] && (|src_data[i*BTN_W +: BTN_W])) ? SEL_W'(i) : nz_idx_s;
            nz_hit_s   = nz_hit_s | (src_valid[i] && (|src_data[i*BTN_W +: BTN_W]));
            held_idx_s = (|hold_s[i]) ? SEL_W'(i) : held_idx_s;
            held_hit_s = held_hit_s | (|hold_s[i]);
            or_s       = or_s | hold_s[i];
        end
        if (nz_hit_s) begin
            owner_next_s = nz_idx_s;
        end else if ((hold_s[owner_r] == {BTN_W{1'b0}}) && held_hit_s) begin
            owner_next_s = held_idx_s;
        end else begin
            owner_next_s = owner_r;
        end
    end

    // Mode mux; the reserved encoding behaves as FIXED.
    always_comb begin
        vector_s = {BTN_W{1'b0}};
        act_s    = {SEL_W{1'b0}};
        case (mode_e'(mode))
            MODE_AUTO: begin
                vector_s = hold_s[owner_r];
                act_s    = owner_r;
            end
            MODE_MERGE: begin
                vector_s = or_s;
                act_s    = {SEL_W{1'b0}};
            end
            default: begin
                if (int'(sel) < N_SRC) begin
                    vector_s = hold_s[sel];
                    act_s    = sel;
                end else begin
                    vector_s = {BTN_W{1'b0}};
                    act_s    = {SEL_W{1'b0}};
                end
            end
        endcase
    end

    // Selection registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner_r      <= {SEL_W{1'b0}};
            merged_btn_r <= {BTN_W{1'b0}};
            active_src_r <= {SEL_W{1'b0}};
        end else begin
            owner_r      <= owner_next_s;
            merged_btn_r <= vector_s;
            active_src_r <= act_s;
        end
    end

    // Console pins are asynchronous: two flops each, plus a third on clock for edge detect.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_meta_r  <= 1'b0;
            sclk_sync_r  <= 1'b0;
            sclk_prev_r  <= 1'b0;
            latch_meta_r <= 1'b0;
            latch_sync_r <= 1'b0;
        end else begin
            sclk_meta_r  <= snes_clk;
            sclk_sync_r  <= sclk_meta_r;
            sclk_prev_r  <= sclk_sync_r;
            latch_meta_r <= snes_latch;
            latch_sync_r <= latch_meta_r;
        end
    end

    assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;

    // Latch has priority over a coincident clock edge; shifts past the frame end feed 1s.
    always_comb begin
        shreg_next_s = shreg_r;
        cnt_next_s   = cnt_r;
        done_next_s  = 1'b0;
        if (latch_sync_r) begin
            shreg_next_s = build_frame(merged_btn_r);
            cnt_next_s   = {CNT_W{1'b0}};
        end else if (sclk_rise_s) begin
            shreg_next_s              = shreg_r >> 1;
            shreg_next_s[FRAME_W-1]   = 1'b1;
            if (cnt_r != CNT_W'(FRAME_W)) begin
                cnt_next_s  = cnt_r + CNT_W'(1);
                done_next_s = (cnt_r == CNT_W'(FRAME_W - 1));
            end else begin
                cnt_next_s  = cnt_r;
                done_next_s = 1'b0;
            end
        end else begin
            shreg_next_s = shreg_r;
        end
    end

    // Shift register and serial output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg_r      <= {FRAME_W{1'b1}};
            cnt_r        <= {CNT_W{1'b0}};
            frame_done_r <= 1'b0;
            snes_out_r   <= 1'b1;
        end else begin
            shreg_r      <= shreg_next_s;
            cnt_r        <= cnt_next_s;
            frame_done_r <= done_next_s;
            snes_out_r   <= shreg_next_s[0];
        end
    end

    assign snes_out   = snes_out_r;
    assign active_src = active_src_r;
    assign merged_btn = merged_btn_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_snes_input_arbiter.sv
// Directed bench for snes_input_arbiter: reset, hold/timeout, the three modes and
// the console latch/clock serialisation, with hand-computed expectations.
module tb_snes_input_arbiter;
    import snes_pkg::*;

    localparam int N_SRC = 3;
    localparam int BTN_W = 12;
    localparam int FRAME_W = 16;
    localparam int HOLD = 100;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [N_SRC*BTN_W-1:0] src_data;
    logic [N_SRC-1:0]       src_valid;
    logic [1:0]             mode;
    logic [1:0]             sel;
    logic                   snes_clk;
    logic                   snes_latch;
    logic                   snes_out;
    logic [1:0]             active_src;
    logic [BTN_W-1:0]       merged_btn;
    logic                   frame_done;

    int n_cmp = 0;
    int n_mis = 0;
    int done_cnt = 0;

    snes_input_arbiter #(
        .N_SRC      (N_SRC),
        .BTN_W      (BTN_W),
        .FRAME_W    (FRAME_W),
        .HOLD_CYCLES(HOLD),
        .HOLD_MASK  (3'b110)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .src_data  (src_data),
        .src_valid (src_valid),
        .mode      (mode),
        .sel       (sel),
        .snes_clk  (snes_clk),
        .snes_latch(snes_latch),
        .snes_out  (snes_out),
        .active_src(active_src),
        .merged_btn(merged_btn),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int ch, input logic [BTN_W-1:0] d);
        src_data[ch*BTN_W +: BTN_W] = d;
        src_valid[ch] = 1'b1;
        tick(1);
        src_valid[ch] = 1'b0;
    endtask

    task automatic sclk_cycle();
        snes_clk = 1'b1;
        tick(6);
        snes_clk = 1'b0;
        tick(6);
    endtask

    task automatic latch_pulse(input logic with_clk);
        snes_latch = 1'b1;
        snes_clk = with_clk;
        tick(6);
        snes_latch = 1'b0;
        snes_clk = 1'b0;
        tick(6);
    endtask

    task automatic shift_bits(output logic [FRAME_W-1:0] bits);
        for (int k = 0; k < FRAME_W; k++) begin
            bits[k] = snes_out;
            sclk_cycle();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    logic [FRAME_W-1:0] bits;
    int d0;
    int hits;

    initial begin
        reset_n = 1'b0;
        src_data = '0;
        src_valid = '0;
        mode = 2'd0;
        sel = 2'd0;
        snes_clk = 1'b0;
        snes_latch = 1'b0;
        tick(3);
        check_eq("rst_snes_out", 32'(snes_out), 32'd1);
        check_eq("rst_merged", 32'(merged_btn), 32'd0);
        check_eq("rst_active", 32'(active_src), 32'd0);
        check_eq("rst_done", 32'(frame_done), 32'd0);
        reset_n = 1'b1;
        tick(1);

        // Reset in the middle of a frame
        strobe(0, 12'h0FF);
        tick(3);
        check_eq("t1_merged", 32'(merged_btn), 32'h0FF);
        latch_pulse(1'b0);
        repeat (5) sclk_cycle();
        check_eq("t1_bit5_pre", 32'(snes_out), 32'd0);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check_eq("t1_out_after_rst", 32'(snes_out), 32'd1);
        check_eq("t1_merged_after_rst", 32'(merged_btn), 32'd0);
        tick(2);

        // FIXED, full frame with B pressed
        strobe(0, 12'(1 << BTN_B));
        tick(3);
        check_eq("t2_merged", 32'(merged_btn), 32'h001);
        d0 = done_cnt;
        latch_pulse(1'b0);
        shift_bits(bits);
        check_eq("t2_frame", 32'(bits), 32'hFFFE);
        check_eq("t2_done_once", 32'(done_cnt - d0), 32'd1);

        sel = 2'd3;
        tick(3);
        check_eq("fixed_sel3_merged", 32'(merged_btn), 32'd0);
        check_eq("fixed_sel3_active", 32'(active_src), 32'd0);

        // Timed channel: visible for exactly HOLD cycles
        sel = 2'd1;
        src_data[BTN_W +: BTN_W] = 12'(1 << BTN_UP);
        src_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        src_valid[1] = 1'b0;
        hits = 0;
        for (int k = 1; k <= HOLD + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (merged_btn == 12'h010) hits++;
            if (k == 1) check_eq("t3_first", 32'(merged_btn), 32'h010);
            if (k == 1) check_eq("t3_active", 32'(active_src), 32'd1);
            if (k == HOLD) check_eq("t3_last_held", 32'(merged_btn), 32'h010);
            if (k == HOLD + 1) check_eq("t3_released", 32'(merged_btn), 32'h000);
        end
        check_eq("t3_hold_len", 32'(hits), 32'(HOLD));

        // AUTO ownership
        do_reset();
        mode = 2'd1;
        strobe(1, 12'(1 << BTN_RIGHT));
        tick(3);
        check_eq("t4_own1", 32'(active_src), 32'd1);
        check_eq("t4_vec1", 32'(merged_btn), 32'h080);
        strobe(2, 12'(1 << BTN_A));
        tick(3);
        check_eq("t4_own2", 32'(active_src), 32'd2);
        check_eq("t4_vec2", 32'(merged_btn), 32'h100);
        strobe(2, 12'h000);
        tick(3);
        check_eq("t4_back1", 32'(active_src), 32'd1);
        check_eq("t4_back1_vec", 32'(merged_btn), 32'h080);
        tick(110);
        check_eq("t4_idle_own", 32'(active_src), 32'd1);
        check_eq("t4_idle_vec", 32'(merged_btn), 32'h000);
        strobe(0, 12'(1 << BTN_SELECT));
        tick(3);
        check_eq("t4_own0", 32'(active_src), 32'd0);
        strobe(2, 12'(1 << BTN_A));
        tick(3);
        check_eq("t4_own2b", 32'(active_src), 32'd2);
        tick(105);
        check_eq("t4_expire_own", 32'(active_src), 32'd0);
        check_eq("t4_expire_vec", 32'(merged_btn), 32'h004);

        // MERGE
        mode = 2'd2;
        strobe(0, 12'(1 << BTN_B));
        strobe(2, 12'(1 << BTN_R));
        tick(3);
        check_eq("t5_merged", 32'(merged_btn), 32'h801);
        check_eq("t5_active", 32'(active_src), 32'd0);
        latch_pulse(1'b0);
        shift_bits(bits);
        check_eq("t5_frame", 32'(bits), 32'hF7FE);

        // Latch coinciding with a clock edge, then over-clocking past the frame
        mode = 2'd0;
        sel = 2'd0;
        tick(3);
        d0 = done_cnt;
        latch_pulse(1'b1);
        check_eq("t6_load_only", 32'(snes_out), 32'd0);
        shift_bits(bits);
        check_eq("t6_frame", 32'(bits), 32'hFFFE);
        sclk_cycle();
        check_eq("t6_17th", 32'(snes_out), 32'd1);
        sclk_cycle();
        check_eq("t6_18th", 32'(snes_out), 32'd1);
        check_eq("t6_done_once", 32'(done_cnt - d0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
